// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared encodings, FSM states and access checks for dmem_arbiter
package dmem_arb_pkg;

  localparam int DEFAULT_MEM_BYTES = 4096;

  typedef enum logic [1:0] {
    SZ_WORD    = 2'b00,
    SZ_BYTE_S  = 2'b01,
    SZ_BYTE_U  = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  // Word accesses must be aligned and fit entirely below limit.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] limit);
    case (size)
      SZ_WORD:              access_err = (addr[1:0] != 2'b00) || (addr > (limit - 32'd4));
      SZ_BYTE_S, SZ_BYTE_U: access_err = (addr >= limit);
      default:              access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; grant is the winning requester index
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter with fixed 3-cycle transactions
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [1:0]       m0_size,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_ack,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  output logic [CNT_W-1:0] m0_count,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [1:0]       m1_size,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_ack,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic [CNT_W-1:0] m1_count,
  output logic             mem_wren,
  output logic             mem_sb,
  output logic             mem_lb,
  output logic             mem_lbu,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_e      state, state_nxt;
  logic [1:0]  req;
  logic        grant;
  logic        last_q;
  logic        gnt_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic        acc_err;
  logic        is_byte;
  logic        ack;

  assign req     = {m1_req, m0_req};
  assign acc_err = access_err(size_q, addr_q, MEM_LIMIT);
  assign is_byte = (size_q == SZ_BYTE_S) || (size_q == SZ_BYTE_U);

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    mem_wren  = 1'b0;
    mem_sb    = 1'b0;
    mem_lb    = 1'b0;
    mem_lbu   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (|req) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_RESP;
        mem_wren  = we_q && !acc_err;
        mem_sb    = we_q && is_byte;
        mem_lb    = !we_q && (size_q == SZ_BYTE_S);
        mem_lbu   = !we_q && (size_q == SZ_BYTE_U);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        ack       = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign m0_ack   = ack && !gnt_q;
  assign m1_ack   = ack && gnt_q;
  assign m0_rdata = m0_ack ? resp_data_q : '0;
  assign m1_rdata = m1_ack ? resp_data_q : '0;
  assign m0_err   = m0_ack && resp_err_q;
  assign m1_err   = m1_ack && resp_err_q;

  // Request fields are captured once at grant so requesters may change them freely afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      m0_count    <= '0;
      m1_count    <= '0;
    end else begin
      if (state == ST_IDLE && |req) begin
        gnt_q   <= grant;
        last_q  <= grant;
        we_q    <= grant ? m1_we    : m0_we;
        size_q  <= grant ? m1_size  : m0_size;
        addr_q  <= grant ? m1_addr  : m0_addr;
        wdata_q <= grant ? m1_wdata : m0_wdata;
      end
      if (state == ST_ISSUE) begin
        resp_err_q  <= acc_err;
        resp_data_q <= (we_q || acc_err) ? '0 : mem_rdata;
      end
      if (m0_ack && m0_count != '1) m0_count <= m0_count + CNT_W'(1);
      if (m1_ack && m1_count != '1) m1_count <= m1_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-array memory model
module tb_dmem_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [1:0]    m0_size = 2'b00;
  logic [31:0]   m0_addr = '0, m0_wdata = '0;
  logic          m0_ack, m0_err;
  logic [31:0]   m0_rdata;
  logic [CW-1:0] m0_count;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [1:0]    m1_size = 2'b00;
  logic [31:0]   m1_addr = '0, m1_wdata = '0;
  logic          m1_ack, m1_err;
  logic [31:0]   m1_rdata;
  logic [CW-1:0] m1_count;
  logic          mem_wren, mem_sb, mem_lb, mem_lbu;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MEM_BYTES(4096), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_count(m0_count),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err), .m1_count(m1_count),
    .mem_wren(mem_wren), .mem_sb(mem_sb), .mem_lb(mem_lb), .mem_lbu(mem_lbu),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  logic        mem_clear = 1'b1;
  int          wren_cnt;

  assign ma = mem_addr[11:0];

  always_comb begin
    if (mem_lb)       mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
    else if (mem_lbu) mem_rdata = {24'h0, mem[ma]};
    else              mem_rdata = {mem[12'(ma + 12'd3)], mem[12'(ma + 12'd2)], mem[12'(ma + 12'd1)], mem[ma]};
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      wren_cnt <= 0;
    end else if (mem_wren) begin
      wren_cnt <= wren_cnt + 1;
      if (mem_sb) begin
        mem[ma] <= mem_wdata[7:0];
      end else begin
        mem[ma]                <= mem_wdata[7:0];
        mem[12'(ma + 12'd1)]   <= mem_wdata[15:8];
        mem[12'(ma + 12'd2)]   <= mem_wdata[23:16];
        mem[12'(ma + 12'd3)]   <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (m0_ack && m1_ack) begin
      checks++; errors++;
      $display("FAIL both_ack: m0_ack and m1_ack high together at %0t", $time);
    end
    if (m0_ack) begin
      checks++;
      if (prev_ack0) begin errors++; $display("FAIL m0_ack_width: ack high 2 cycles at %0t", $time); end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL m0_resp: unexpected ack rdata=%h", m0_rdata);
      end else begin
        e = sb.pop_front();
        if (e.port !== 0 || m0_rdata !== e.rdata || m0_err !== e.err) begin
          errors++;
          $display("FAIL m0_resp: got port=0 rdata=%h err=%b, required port=%0d rdata=%h err=%b",
                   m0_rdata, m0_err, e.port, e.rdata, e.err);
        end
      end
    end
    if (m1_ack) begin
      checks++;
      if (prev_ack1) begin errors++; $display("FAIL m1_ack_width: ack high 2 cycles at %0t", $time); end
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL m1_resp: unexpected ack rdata=%h", m1_rdata);
      end else begin
        e = sb.pop_front();
        if (e.port !== 1 || m1_rdata !== e.rdata || m1_err !== e.err) begin
          errors++;
          $display("FAIL m1_resp: got port=1 rdata=%h err=%b, required port=%0d rdata=%h err=%b",
                   m1_rdata, m1_err, e.port, e.rdata, e.err);
        end
      end
    end
    prev_ack0 = m0_ack;
    prev_ack1 = m1_ack;
  end

  task automatic push_exp(input int port, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drive(input int port, input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic access(input int port, input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input string name);
    int   cyc;
    logic got;
    push_exp(port, exp_rdata, exp_err);
    @(negedge clk);
    drive(port, 1'b1, we, size, addr, wdata);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (mem_wren !== (we && !exp_err) || mem_addr !== addr) begin
          errors++;
          $display("FAIL %s_issue: mem_wren=%b mem_addr=%h, required mem_wren=%b mem_addr=%h",
                   name, mem_wren, mem_addr, we && !exp_err, addr);
        end
      end
      got = (port == 0) ? m0_ack : m1_ack;
    end
    checks++;
    if (!got || cyc != 2) begin
      errors++;
      $display("FAIL %s_latency: ack after %0d cycles (seen=%b), required 2", name, cyc, got);
    end
    checks++;
    if (mem_wren !== 1'b0 || mem_addr !== 32'h0 || mem_sb !== 1'b0 || mem_lb !== 1'b0 || mem_lbu !== 1'b0) begin
      errors++;
      $display("FAIL %s_mem_idle: mem outputs active in RESP wren=%b addr=%h", name, mem_wren, mem_addr);
    end
    drive(port, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_count !== '0 || m1_count !== '0 ||
        m0_rdata !== 32'h0 || m0_err !== 1'b0 || mem_wren !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b%b count=%h/%h rdata=%h wren=%b, required all 0",
               m0_ack, m1_ack, m0_count, m1_count, m0_rdata, mem_wren);
    end
    rst = 1'b0;
    mem_clear = 1'b0;
  endtask

  task automatic test_word;
    access(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "m0_store_word");
    access(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "m0_load_word");
    @(negedge clk);
    checks++;
    if (m0_count !== 4'd2) begin
      errors++; $display("FAIL m0_count_word: got %0d, required 2", m0_count);
    end
  endtask

  task automatic test_byte;
    access(1, 1'b1, 2'b01, 32'h13, 32'hAAAAAA80, 32'h0, 1'b0, "m1_store_byte");
    access(1, 1'b0, 2'b01, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "m1_load_bs");
    access(1, 1'b0, 2'b10, 32'h13, 32'h0, 32'h00000080, 1'b0, "m1_load_bu");
    access(1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "m1_load_word");
    @(negedge clk);
    checks++;
    if (m1_count !== 4'd4) begin
      errors++; $display("FAIL m1_count_byte: got %0d, required 4", m1_count);
    end
  endtask

  task automatic test_contention;
    int order[3];
    int when[3];
    int n;
    int cyc;
    push_exp(0, 32'h80ADBEEF, 1'b0);
    push_exp(1, 32'h000000BE, 1'b0);
    push_exp(0, 32'h80ADBEEF, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 32'h11, 32'h0);
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) begin
        order[n] = m1_ack ? 1 : 0;
        when[n] = cyc;
        n++;
      end
    end
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL rr_count: got %0d acks, required 3", n);
    end else begin
      checks++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
        errors++; $display("FAIL rr_order: got %0d,%0d,%0d, required 0,1,0", order[0], order[1], order[2]);
      end
      checks++;
      if (when[0] != 2 || when[1] != 5 || when[2] != 8) begin
        errors++; $display("FAIL rr_timing: acks at %0d,%0d,%0d, required 2,5,8", when[0], when[1], when[2]);
      end
    end
  endtask

  task automatic test_req_drop;
    push_exp(0, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'b00, 32'h20, 32'h12345678);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'b01, 32'h24, 32'hFFFFFFFF);
    checks++;
    if (mem_wren !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL drop_issue: wren=%b addr=%h wdata=%h, required 1 00000020 12345678",
               mem_wren, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1) begin
      errors++; $display("FAIL drop_ack: m0_ack=%b, required 1", m0_ack);
    end
    access(0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h12345678, 1'b0, "drop_load");
  endtask

  task automatic test_errors;
    int wc;
    wc = wren_cnt;
    access(0, 1'b1, 2'b00, 32'h0FFE, 32'h11111111, 32'h0, 1'b1, "err_store_misalign");
    access(0, 1'b1, 2'b00, 32'h1000, 32'h22222222, 32'h0, 1'b1, "err_store_oob");
    access(1, 1'b0, 2'b11, 32'h20, 32'h0, 32'h0, 1'b1, "err_size11");
    access(0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 1'b1, "err_byte_oob");
    @(negedge clk);
    checks++;
    if (wren_cnt != wc) begin
      errors++; $display("FAIL err_wren: %0d writes during error accesses, required 0", wren_cnt - wc);
    end
    access(0, 1'b0, 2'b00, 32'h0FFC, 32'h0, 32'h0, 1'b0, "edge_word_ok");
    access(0, 1'b0, 2'b01, 32'h0FFF, 32'h0, 32'h0, 1'b0, "edge_byte_ok");
  endtask

  task automatic test_reset_abort;
    logic seen;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m1_ack !== 1'b0 || m0_count !== '0 || m1_count !== '0 || mem_wren !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: m1_ack=%b counts=%h/%h mem_addr=%h, required 0",
               m1_ack, m0_count, m1_count, mem_addr);
    end
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m1_ack) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_ack: m1_ack seen=%b after reset, required 0", seen);
    end
    access(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "post_reset_load");
    @(negedge clk);
    checks++;
    if (m0_count !== 4'd1 || m1_count !== 4'd0) begin
      errors++; $display("FAIL post_reset_count: got %0d/%0d, required 1/0", m0_count, m1_count);
    end
  endtask

  task automatic test_saturate;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) access(0, 1'b0, 2'b00, 32'h40, 32'h0, 32'h0, 1'b0, "sat_fill");
    @(negedge clk);
    checks++;
    if (m0_count !== 4'hF) begin
      errors++; $display("FAIL sat_reach: got %h, required f", m0_count);
    end
    for (int i = 0; i < 3; i++) access(0, 1'b0, 2'b00, 32'h40, 32'h0, 32'h0, 1'b0, "sat_over");
    @(negedge clk);
    checks++;
    if (m0_count !== 4'hF || m1_count !== 4'h0) begin
      errors++; $display("FAIL sat_hold: got %h/%h, required f/0", m0_count, m1_count);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_contention();
    test_req_drop();
    test_errors();
    test_reset_abort();
    test_saturate();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 4096: size of the attached data memory in bytes.
REQ-002 Parameter CNT_W, default 16: width of the per-requester access counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 m0_req  in  1  requester 0 access request; held with its fields until m0_ack.
REQ-006 m0_we  in  1  1 = store, 0 = load.
REQ-007 m0_size  in  2  access size: 00 = word, 01 = byte signed, 10 = byte unsigned, 11 = illegal.
REQ-008 m0_addr  in  32  byte address.
REQ-009 m0_wdata  in  32  store data; for byte stores, bits [7:0] are used.
REQ-010 m0_ack  out  1  one-cycle completion pulse.
REQ-011 m0_rdata  out  32  load result, valid while m0_ack is high.
REQ-012 m0_err  out  1  error flag, valid while m0_ack is high.
REQ-013 m0_count  out  CNT_W  saturating count of completed m0 accesses.
REQ-014 m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err, m1_count: same directions, widths and meanings as the m0 ports, for requester 1.
REQ-015 mem_wren  out  1  memory write enable.
REQ-016 mem_sb  out  1  byte-store select.
REQ-017 mem_lb  out  1  signed byte-load select.
REQ-018 mem_lbu  out  1  unsigned byte-load select.
REQ-019 mem_addr  out  32  memory byte address.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  combinational memory read data, little-endian.

Function
REQ-022 The FSM SHALL have three states, IDLE, ISSUE and RESP; the transitions are IDLE->ISSUE when any req is high, ISSUE->RESP always, and RESP->IDLE always.
REQ-023 In IDLE with one req high, that requester SHALL be granted; with both high, the requester not granted last SHALL be granted (round-robin).
REQ-024 The last-grant register SHALL reset to 1, so m0 wins the first contention.
REQ-025 On the IDLE->ISSUE edge, the granted requester's we/size/addr/wdata SHALL be latched internally; later input changes have no effect on the transaction.
REQ-026 In ISSUE, mem_addr and mem_wdata SHALL carry the latched values; mem_sb = we&&byte; mem_lb = !we&&size==01; mem_lbu = !we&&size==10; mem_wren = we&&!error; mem_wren is high for exactly this one cycle.
REQ-027 At the end of ISSUE, mem_rdata SHALL be registered as the response data for loads; the response data for stores and for errors is 0.
REQ-028 In RESP, the granted requester's ack SHALL be 1 for exactly one cycle, with rdata and err driven; the other requester's ack SHALL be 0.
REQ-029 Latency SHALL be a fixed 2 cycles from the first sampled req to ack, and 3 cycles per transaction minimum, i.e. back-to-back.
REQ-030 An access is an error if size==11, or a word access has addr[1:0]!=0, or a word access has addr>MEM_BYTES-4, or a byte access has addr>=MEM_BYTES.
REQ-031 An error access SHALL keep mem_wren=0, return err=1 and rdata=0, and still produce ack.
REQ-032 If req drops after grant, the transaction SHALL still complete and ack SHALL still pulse.
REQ-033 A requester whose req is still high in the cycle after its ack SHALL be treated as a new request.
REQ-034 mN_count SHALL increment on each mN_ack, including errors, and saturate at all-ones.
REQ-035 Outside ISSUE, all mem_* outputs SHALL be 0.

Reset
REQ-036 While rst=1 at a clock edge: state SHALL go to IDLE, acks/err/rdata/counters to 0, last-grant to 1, and all mem_* outputs to 0 from that edge.
REQ-037 A reset asserted during ISSUE or RESP SHALL abort the transaction with no ack; a write already issued is not undone.

Structure
REQ-038 Package dmem_arb_pkg SHALL hold the size encodings, the FSM state enum and the default MEM_BYTES.
REQ-039 The round-robin grant logic SHALL be a sub-module rr_arb2, with inputs req[1:0] and last, and output grant.

Verification
REQ-040 m0 stores word 0xDEADBEEF at 0x10, then loads it -> ack 2 cycles after req, rdata=0xDEADBEEF, err=0, m0_count=2.
REQ-041 m1 stores byte 0x80 at 0x13, then loads it signed and unsigned -> rdata 0xFFFFFF80 and 0x00000080.
REQ-042 m0 and m1 req in the same cycle, held high continuously -> grants alternate m0, m1, m0; each ack pulse lasts one cycle.
REQ-043 Word store to 0x0FFE and to 0x1000, and a size=11 access -> err=1 on each, rdata=0, mem_wren never asserted.
REQ-044 rst pulsed during ISSUE of an m1 load -> no m1_ack, state IDLE, counters 0, and the next m0 request completes normally.
REQ-045 Drive m0 with 65535+3 accesses (CNT_W=16) -> m0_count holds at 0xFFFF.
